// File: rtl/cbus_rr_arbiter_if.sv
// Cache-bus request/response types and the bundle that connects the
// requesters and the downstream port to the round-robin arbiter.
package cbus_pkg;
    typedef struct packed {
        logic        valid;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [15:0] data;
    } cbus_resp_t;
endpackage

interface cbus_rr_arbiter_if #(
    parameter int NUM_INPUTS = 2
);
    import cbus_pkg::*;

    cbus_req_t                 ireqs  [NUM_INPUTS];
    cbus_resp_t                iresps [NUM_INPUTS];
    cbus_req_t                 oreq;
    cbus_resp_t                oresp;
    logic [NUM_INPUTS-1:0]     grant_oh;
    logic                      busy;
    logic                      timeout_err;

    modport slave (
        input  ireqs,
        input  oresp,
        output iresps,
        output oreq,
        output grant_oh,
        output busy,
        output timeout_err
    );

    modport master (
        output ireqs,
        output oresp,
        input  iresps,
        input  oreq,
        input  grant_oh,
        input  busy,
        input  timeout_err
    );
endinterface

// File: rtl/cbus_rr_arbiter.sv
// Round-robin arbiter sharing one cache-bus port among NUM_INPUTS requesters;
// a grant lasts a whole transaction and a sticky watchdog flags stalled ones.
module cbus_rr_arbiter
    import cbus_pkg::*;
#(
    parameter int NUM_INPUTS = 2,
    parameter int TIMEOUT    = 1024
) (
    input  logic               clk,
    input  logic               reset,
    cbus_rr_arbiter_if.slave   bus
);
    localparam int IDX_W = $clog2(NUM_INPUTS > 1 ? NUM_INPUTS : 2);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);
    localparam logic [IDX_W:0]   N_EXT    = (IDX_W + 1)'(NUM_INPUTS);
    localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT);
    localparam logic [WD_W-1:0]  WD_WARN  = WD_W'(TIMEOUT - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [IDX_W-1:0]   r_owner;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [WD_W-1:0]    r_wd_cnt;
    logic               r_timeout_err;
    logic [IDX_W-1:0]   w_winner;
    logic               w_found;
    logic [IDX_W:0]     w_cand;
    logic               w_final_beat;

    assign w_final_beat    = bus.oresp.ready & bus.oresp.last;
    assign bus.timeout_err = r_timeout_err;

    // Search starts at the round-robin pointer and wraps, so the most recent owner goes last.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            w_cand = {1'b0, r_rr_ptr} + (IDX_W + 1)'(i);
            if (w_cand >= N_EXT) begin
                w_cand = w_cand - N_EXT;
            end
            if (!w_found && bus.ireqs[w_cand[IDX_W-1:0]].valid) begin
                w_found  = 1'b1;
                w_winner = w_cand[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // The owner's request is forwarded live, so a dropped valid reaches downstream as-is.
    always_comb begin
        w_next_state = r_state;
        bus.oreq     = '0;
        bus.iresps   = '{default: '0};
        bus.grant_oh = '0;
        bus.busy     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_next_state = S_BUSY;
                end
            end
            S_BUSY: begin
                bus.oreq              = bus.ireqs[r_owner];
                bus.iresps[r_owner]   = bus.oresp;
                bus.grant_oh          = NUM_INPUTS'(1) << r_owner;
                bus.busy              = 1'b1;
                if (w_final_beat) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner       <= '0;
            r_rr_ptr      <= '0;
            r_wd_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == S_IDLE && w_found) begin
                r_owner  <= w_winner;
                r_wd_cnt <= '0;
            end
            if (r_state == S_BUSY) begin
                if (w_final_beat) begin
                    r_rr_ptr <= (r_owner == LAST_IDX) ? '0 : r_owner + 1'b1;
                end else begin
                    if (r_wd_cnt != WD_MAX) begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                    end
                    // Flag only; the grant is kept so the transaction can still finish.
                    if (r_wd_cnt >= WD_WARN) begin
                        r_timeout_err <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Scoreboard bench for cbus_rr_arbiter: directed requester/downstream traffic,
// expected grants queued up front and checked by an independent monitor.
module tb_cbus_rr_arbiter;
    import cbus_pkg::*;

    localparam int N  = 2;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cbus_rr_arbiter_if #(.NUM_INPUTS(N)) bus();

    cbus_rr_arbiter #(.NUM_INPUTS(N), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    typedef struct {
        int        owner;
        int        len;
        int        gap;
        cbus_req_t req;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    int   req_total [N];
    int   txn_cnt   [N];
    int   done_seen [N];
    int   beat_len   = 1;
    int   beat_delay = 1;

    logic in_txn    = 1'b0;
    logic prev_busy = 1'b0;
    exp_t cur;
    int   beats    = 0;
    int   idle_cnt = 0;

    function automatic cbus_req_t mk_req(int i, int n);
        cbus_req_t r;
        r.valid = 1'b1;
        r.we    = i[0];
        r.addr  = 16'hA000 + 16'(i * 256 + n);
        r.wdata = 16'h5000 + 16'(i * 16 + n);
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input int owner, input int n, input int len, input int gap);
        exp_t e;
        e.owner = owner;
        e.len   = len;
        e.gap   = gap;
        e.req   = mk_req(owner, n);
        exp_q.push_back(e);
    endtask

    // Requesters and downstream model: requests stay valid until their last beat is seen.
    initial begin
        int k;
        k = 0;
        for (int i = 0; i < N; i++) bus.ireqs[i] = '0;
        bus.oresp = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                txn_cnt[i]   = done_seen[i];
                bus.ireqs[i] = (req_total[i] > txn_cnt[i]) ? mk_req(i, txn_cnt[i]) : '0;
            end
            if (bus.busy) begin
                k++;
                if (k > beat_delay && k <= beat_delay + beat_len) begin
                    bus.oresp.ready = 1'b1;
                    bus.oresp.last  = (k == beat_delay + beat_len);
                    bus.oresp.data  = 16'hD000 + 16'(k);
                end else begin
                    bus.oresp = '0;
                end
            end else begin
                k = 0;
                bus.oresp = '0;
            end
        end
    end

    // Monitor: pops an expectation at each grant and checks forwarding every cycle.
    always @(negedge clk) begin
        if (rst) begin
            in_txn    = 1'b0;
            prev_busy = 1'b0;
            idle_cnt  = 0;
        end else begin
            if (bus.busy && !prev_busy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_grant actual=%0h required=none", bus.grant_oh);
                end else begin
                    cur    = exp_q.pop_front();
                    in_txn = 1'b1;
                    beats  = 0;
                    if (cur.gap >= 0) chk("idle_gap", idle_cnt, cur.gap);
                end
                idle_cnt = 0;
            end
            if (bus.busy && in_txn) begin
                chk("grant_oh", bus.grant_oh, 64'(1) << cur.owner);
                chk("oreq", bus.oreq, cur.req);
                for (int i = 0; i < N; i++) begin
                    if (i != cur.owner) chk("iresps_other", bus.iresps[i], '0);
                end
                if (bus.oresp.ready) begin
                    beats++;
                    chk("iresps_owner", bus.iresps[cur.owner], bus.oresp);
                    if (bus.oresp.last) done_seen[cur.owner]++;
                end
            end
            if (!bus.busy) begin
                if (prev_busy && in_txn) begin
                    chk("beats", beats, cur.len);
                    in_txn = 1'b0;
                end
                idle_cnt++;
                chk("idle_grant", bus.grant_oh, '0);
                chk("idle_oreq", bus.oreq, '0);
                for (int i = 0; i < N; i++) chk("idle_iresps", bus.iresps[i], '0);
            end
            prev_busy = bus.busy;
        end
    end

    task automatic wait_done(input int max_cyc);
        int n;
        n = 0;
        while (n < max_cyc && !(exp_q.size() == 0 && !in_txn && !bus.busy &&
                                 req_total[0] == txn_cnt[0] && req_total[1] == txn_cnt[1])) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= max_cyc) begin
            errors++;
            $display("FAIL wait_done actual=%0d cycles required=<%0d queue=%0d", n, max_cyc, exp_q.size());
        end
    endtask

    task automatic wait_busy(input int max_cyc);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!bus.busy && n < max_cyc);
        chk("wait_busy", bus.busy, 1'b1);
    endtask

    initial begin
        logic exp_busy [5];
        exp_busy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_grant", bus.grant_oh, '0);
        chk("rst_timeout", bus.timeout_err, 1'b0);
        chk("rst_oreq_valid", bus.oreq.valid, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        chk("idle_busy", bus.busy, 1'b0);

        // Single request from requester 1, last on the third busy cycle
        beat_delay = 2;
        beat_len   = 1;
        push(1, txn_cnt[1], 1, -1);
        req_total[1]++;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            chk("t2_busy", bus.busy, exp_busy[c]);
            if (c == 1) chk("t2_grant", bus.grant_oh, 2'b10);
        end
        wait_done(20);

        // Both requesters continuously asserting: grants alternate 0,1,0,1
        beat_delay = 1;
        beat_len   = 1;
        push(0, txn_cnt[0],     1, -1);
        push(1, txn_cnt[1],     1, 1);
        push(0, txn_cnt[0] + 1, 1, 1);
        push(1, txn_cnt[1] + 1, 1, 1);
        req_total[0] += 2;
        req_total[1] += 2;
        wait_done(60);

        // Burst of 4 to owner 0 while requester 1 waits
        beat_delay = 1;
        beat_len   = 4;
        push(0, txn_cnt[0], 4, -1);
        push(1, txn_cnt[1], 4, 1);
        req_total[0]++;
        req_total[1]++;
        wait_done(60);

        // Watchdog: no last for 10 busy cycles
        chk("t5_pre_timeout", bus.timeout_err, 1'b0);
        beat_delay = 10;
        beat_len   = 1;
        push(0, txn_cnt[0], 1, -1);
        req_total[0]++;
        wait_busy(10);
        for (int k = 2; k <= 9; k++) begin
            @(negedge clk);
            #1;
            if (k == 8) chk("t5_timeout_k8", bus.timeout_err, 1'b0);
            if (k == 9) chk("t5_timeout_k9", bus.timeout_err, 1'b1);
        end
        wait_done(30);
        chk("t5_timeout_sticky", bus.timeout_err, 1'b1);

        // Reset during the second beat of a burst owned by requester 1
        beat_delay = 0;
        beat_len   = 4;
        push(1, txn_cnt[1], 4, -1);
        req_total[0]++;
        req_total[1]++;
        wait_busy(10);
        @(posedge clk);
        #2;
        chk("t6_pre_grant", bus.grant_oh, 2'b10);
        chk("t6_pre_beat", bus.iresps[1].ready, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk("t6_async_busy", bus.busy, 1'b0);
        chk("t6_async_grant", bus.grant_oh, '0);
        chk("t6_async_oreq", bus.oreq, '0);
        chk("t6_async_iresp0", bus.iresps[0], '0);
        chk("t6_async_iresp1", bus.iresps[1], '0);
        chk("t6_async_timeout", bus.timeout_err, 1'b0);
        push(0, txn_cnt[0], 4, -1);
        push(1, txn_cnt[1], 4, 1);
        @(posedge clk);
        #3 rst = 1'b0;
        wait_done(60);
        chk("t6_timeout_clear", bus.timeout_err, 1'b0);

        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0t required=<200000", $time);
        $fatal(1, "simulation time limit");
    end
endmodule
